bird_physics: RTL and testbench
===============================

BIRD_PHYSICS -- requirements
Module: bird_physics

Interface
REQ-001 Parameter SCREEN_HEIGHT, default 480: screen height in pixels.
REQ-002 Parameter BIRD_HEIGHT, default 20: bird sprite height in pixels.
REQ-003 Parameter BIRD_START_Y, default 230: bird top-edge y in IDLE.
REQ-004 Parameter GRAVITY, default 1: velocity increment per frame, pixels/frame.
REQ-005 Parameter FLAP_IMPULSE, default 8: upward speed set by a flap; velocity becomes -FLAP_IMPULSE.
REQ-006 Parameter MAX_FALL_VEL, default 10: downward velocity ceiling.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-010 start_button  input  1  level; starts a game from IDLE and returns to IDLE from DEAD.
REQ-011 flap_button  input  1  level; a rising edge requests a flap.
REQ-012 collision_in  input  1  level from the pipe-collision logic; high means the bird hit a pipe.
REQ-013 bird_y  output  10  bird top-edge y, unsigned; 0 is the top of the screen.
REQ-014 bird_vel  output  8  signed two's-complement velocity; positive is downward.
REQ-015 bird_state  output  2  00 IDLE, 01 FLY, 10 DEAD; 11 is never driven.
REQ-016 ground_hit  output  1  high while in DEAD if entry to DEAD was caused by reaching the ground.

Function
REQ-017 State IDLE: bird_y = BIRD_START_Y and bird_vel = 0 are held; start_button high moves to FLY on the next edge.
REQ-018 State FLY: bird_y and bird_vel update only on cycles where frame_tick is high; they hold otherwise.
REQ-019 Flap edge detection: flap_button is registered; a rising edge is (flap_button & ~flap_button_q).
REQ-020 Flap latching: an edge sets flap_pending; flap_pending clears on the next FLY frame_tick.
- An edge in the same cycle as a frame_tick counts for that tick.
- Multiple edges between ticks count as one flap.
REQ-021 Tick update, position: y_next = bird_y + bird_vel, using the pre-tick velocity and computed as an 11-bit signed sum.
REQ-022 Tick update, velocity with a flap: bird_vel becomes -FLAP_IMPULSE.
REQ-023 Tick update, velocity without a flap: bird_vel becomes min(bird_vel + GRAVITY, MAX_FALL_VEL).
REQ-024 Ceiling: if y_next < 0, then bird_y = 0 and bird_vel = 0; this overrides REQ-022/023 and clears flap_pending.
REQ-025 Ground: if y_next >= SCREEN_HEIGHT - BIRD_HEIGHT (460), then:
- bird_y = 460 and bird_vel = 0;
- state becomes DEAD and ground_hit is set.
REQ-026 Pipe collision in FLY: collision_in high moves to DEAD on the next edge with ground_hit = 0.
- It has priority over a same-cycle frame_tick, which performs no position or velocity update.
REQ-027 State DEAD: bird_y and bird_vel hold; flap edges and frame_tick are ignored; start_button high moves to IDLE.
- Entering IDLE this way reloads BIRD_START_Y, zeroes bird_vel, and clears ground_hit and flap_pending.
REQ-028 Flap edges seen in IDLE or DEAD are discarded; flap_pending is 0 on entry to FLY.
REQ-029 Outputs are registered; an update caused by a tick in cycle N is visible in cycle N+1.

Reset
REQ-030 When reset is high at a clock edge, regardless of state:
- state = IDLE, bird_y = BIRD_START_Y, bird_vel = 0;
- ground_hit = 0, flap_pending = 0, flap_button_q = 0.
REQ-031 reset has priority over every other input in the same cycle, including mid-frame while in FLY.

Verification
REQ-032 Free fall: reset, start, then 3 ticks with no flap -> (y, vel) = (230,1), (231,2), (233,3).
REQ-033 Flap: after REQ-032, flap edge then tick -> y=236, vel=-8; next tick -> y=228, vel=-7; two edges before one tick -> a single flap.
REQ-034 Ceiling: force y=5, vel=-8, then tick -> y=0, vel=0, state stays FLY.
REQ-035 Ground and velocity cap: fall with no flaps ->
- vel saturates at 10;
- y clamps at 460, state becomes 10, ground_hit=1;
- further ticks leave y=460.
REQ-036 Collision priority: in FLY, collision_in and frame_tick in the same cycle -> next cycle state=10, y and vel unchanged, ground_hit=0; then start_button -> IDLE with y=230.
REQ-037 Reset mid-flight: reset asserted in the same cycle as a tick and a flap edge -> next cycle state=00, y=230, vel=0, and no flap is taken after the next start.

Source files
------------

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - bird vertical motion: gravity, flap impulse, ceiling/ground clamps, game state
module bird_physics #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int BIRD_HEIGHT   = 20,
  parameter int BIRD_START_Y  = 230,
  parameter int GRAVITY       = 1,
  parameter int FLAP_IMPULSE  = 8,
  parameter int MAX_FALL_VEL  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start_button,
  input  logic              flap_button,
  input  logic              collision_in,
  output logic [9:0]        bird_y,
  output logic signed [7:0] bird_vel,
  output logic [1:0]        bird_state,
  output logic              ground_hit
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FLY  = 2'b01,
    DEAD = 2'b10
  } state_t;

  localparam logic [9:0]        START_Y    = 10'(BIRD_START_Y);
  localparam logic [9:0]        GROUND_Y   = 10'(SCREEN_HEIGHT - BIRD_HEIGHT);
  localparam logic signed [10:0] GROUND_Y11 = 11'(SCREEN_HEIGHT - BIRD_HEIGHT);
  localparam logic signed [7:0] FLAP_VEL   = 8'(-FLAP_IMPULSE);
  localparam logic signed [8:0] GRAV9      = 9'(GRAVITY);
  localparam logic signed [8:0] MAX_VEL9   = 9'(MAX_FALL_VEL);

  state_t state, state_next;

  logic              flap_button_q;
  logic              flap_pending;
  logic              flap_edge;
  logic              flap_now;
  logic signed [10:0] y_sum;
  logic signed [8:0] vel_grav;
  logic signed [7:0] vel_fall;
  logic              hit_ceiling;
  logic              hit_ground;

  assign flap_edge   = flap_button & ~flap_button_q;
  // A flap edge arriving on the tick cycle itself counts for that tick
  assign flap_now    = flap_pending | flap_edge;
  assign y_sum       = $signed({1'b0, bird_y}) + $signed({{3{bird_vel[7]}}, bird_vel});
  assign hit_ceiling = y_sum < 11'sd0;
  assign hit_ground  = y_sum >= GROUND_Y11;
  assign vel_grav    = $signed({bird_vel[7], bird_vel}) + GRAV9;
  assign vel_fall    = (vel_grav > MAX_VEL9) ? MAX_VEL9[7:0] : vel_grav[7:0];
  assign bird_state  = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_button) state_next = FLY;
      FLY: begin
        if (collision_in)
          state_next = DEAD;
        else if (frame_tick && !hit_ceiling && hit_ground)
          state_next = DEAD;
      end
      DEAD: if (start_button) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bird_y        <= START_Y;
      bird_vel      <= '0;
      ground_hit    <= 1'b0;
      flap_pending  <= 1'b0;
      flap_button_q <= 1'b0;
    end else begin
      flap_button_q <= flap_button;
      case (state)
        IDLE: begin
          bird_y       <= START_Y;
          bird_vel     <= '0;
          ground_hit   <= 1'b0;
          flap_pending <= 1'b0;
        end
        FLY: begin
          // Pipe collision wins over a same-cycle tick: no motion update
          if (!collision_in) begin
            if (frame_tick) begin
              flap_pending <= 1'b0;
              if (hit_ceiling) begin
                bird_y   <= '0;
                bird_vel <= '0;
              end else if (hit_ground) begin
                bird_y     <= GROUND_Y;
                bird_vel   <= '0;
                ground_hit <= 1'b1;
              end else begin
                bird_y   <= y_sum[9:0];
                bird_vel <= flap_now ? FLAP_VEL : vel_fall;
              end
            end else if (flap_edge) begin
              flap_pending <= 1'b1;
            end
          end
        end
        DEAD: begin
          flap_pending <= 1'b0;
          if (start_button) begin
            bird_y     <= START_Y;
            bird_vel   <= '0;
            ground_hit <= 1'b0;
          end
        end
        default: flap_pending <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - directed and randomized checks of bird_physics against a frame-level model
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_button = 1'b0;
  logic       flap_button = 1'b0;
  logic       collision_in = 1'b0;
  logic [9:0] bird_y;
  logic [7:0] bird_vel;
  logic [1:0] bird_state;
  logic       ground_hit;

  bird_physics dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .start_button(start_button), .flap_button(flap_button),
    .collision_in(collision_in), .bird_y(bird_y), .bird_vel(bird_vel),
    .bird_state(bird_state), .ground_hit(ground_hit)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: game state 0 idle / 1 fly / 2 dead, plain integer position and velocity
  int m_state, m_y, m_vel;
  bit m_gh, m_pend, m_fq, m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, ft, sb, fb, col);
    bit edge_seen;
    int yn;
    edge_seen = fb && !m_fq;
    if (rst) begin
      m_state = 0; m_y = 230; m_vel = 0; m_gh = 0; m_pend = 0; m_fq = 0;
      m_valid = 1;
      return;
    end
    m_fq = fb;
    if (m_state == 0) begin
      if (sb) begin m_state = 1; m_pend = 0; end
    end else if (m_state == 1) begin
      if (col) begin
        m_state = 2; m_gh = 0;
      end else if (ft) begin
        yn = m_y + m_vel;
        if (yn < 0) begin
          m_y = 0; m_vel = 0;
        end else if (yn >= 460) begin
          m_y = 460; m_vel = 0; m_state = 2; m_gh = 1;
        end else begin
          m_y = yn;
          m_vel = (m_pend || edge_seen) ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
        end
        m_pend = 0;
      end else if (edge_seen) begin
        m_pend = 1;
      end
    end else begin
      if (sb) begin m_state = 0; m_y = 230; m_vel = 0; m_gh = 0; m_pend = 0; end
    end
  endtask

  task automatic cyc(input bit rst, ft, sb, fb, col);
    reset = rst; frame_tick = ft; start_button = sb; flap_button = fb; collision_in = col;
    @(posedge clk);
    #1;
    model_step(rst, ft, sb, fb, col);
    #1;
  endtask

  task automatic lit(input string tag, input int y, input int vel, input int st);
    chk({tag, "_y"}, int'(bird_y), y);
    chk({tag, "_vel"}, int'($signed(bird_vel)), vel);
    chk({tag, "_state"}, int'(bird_state), st);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_y", int'(bird_y), m_y);
      chk("model_vel", int'($signed(bird_vel)), m_vel);
      chk("model_state", int'(bird_state), m_state);
      chk("model_ground_hit", int'(ground_hit), int'(m_gh));
    end
  end

  initial begin
    bit cap_seen;
    cyc(1, 0, 0, 0, 0);
    lit("reset", 230, 0, 0);
    chk("reset_ground_hit", int'(ground_hit), 0);

    // Free fall from start
    cyc(0, 0, 1, 0, 0);
    lit("start", 230, 0, 1);
    cyc(0, 1, 0, 0, 0); lit("fall1", 230, 1, 1);
    cyc(0, 1, 0, 0, 0); lit("fall2", 231, 2, 1);
    cyc(0, 1, 0, 0, 0); lit("fall3", 233, 3, 1);

    // Single flap, then two edges folded into one flap
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0); lit("flap1", 236, -8, 1);
    cyc(0, 1, 0, 0, 0); lit("flap2", 228, -7, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0); lit("dbl_flap", 221, -8, 1);
    cyc(0, 1, 0, 0, 0); lit("dbl_after", 213, -7, 1);

    // Climb into the ceiling with a flap edge on every tick
    for (int i = 0; i < 60 && m_y != 0; i++) begin
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
    end
    lit("ceiling", 0, 0, 1);

    // Fall to the ground, velocity saturating on the way
    cap_seen = 0;
    for (int i = 0; i < 80 && m_state != 2; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (m_vel == 10 && !cap_seen) begin
        cap_seen = 1;
        chk("vel_cap", int'($signed(bird_vel)), 10);
      end
    end
    lit("ground", 460, 0, 2);
    chk("ground_hit_set", int'(ground_hit), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
    end
    lit("dead_hold", 460, 0, 2);

    // Collision beats a same-cycle tick
    cyc(0, 0, 1, 0, 0); lit("dead_restart", 230, 0, 0);
    chk("restart_ground_hit", int'(ground_hit), 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    lit("pre_col", 236, 4, 1);
    cyc(0, 1, 0, 0, 1); lit("collision", 236, 4, 2);
    chk("collision_ground_hit", int'(ground_hit), 0);
    cyc(0, 0, 1, 0, 0); lit("col_restart", 230, 0, 0);

    // Reset in the same cycle as a tick and a flap edge
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("pre_reset", 231, 2, 1);
    cyc(1, 1, 0, 1, 0); lit("mid_reset", 230, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0); lit("no_stale_flap", 230, 1, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 59) == 0);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
